// File: rtl/led_matrix_driver.sv
// Column-multiplexed driver for the 3x3 mole LED matrix, with a hit-clearable mole mask.
// Optional hit flash overlay is enabled by defining WAM_HIT_FLASH_EN.
module led_matrix_driver #(
    parameter logic [15:0] SCAN_DIV     = 16'd8191
`ifdef WAM_HIT_FLASH_EN
    ,
    parameter logic [3:0]  FLASH_FRAMES = 4'd8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_cell,
    input  logic       wr_val,
    input  logic       clear_all,
    input  logic       hit_valid,
    input  logic [3:0] hit_key,
    output logic [2:0] col_n,
    output logic [2:0] row_out,
    output logic [8:0] mask,
    output logic       frame_tick,
    output logic       wr_err
);

    logic [15:0] pre;
    logic [1:0]  col;
    logic        tick;
    logic        hit_ok;
    logic        wr_ok;
    logic [8:0]  mask_next;
    logic [8:0]  display;
    logic [2:0]  rows;

    assign tick   = (pre == SCAN_DIV);
    assign hit_ok = hit_valid && (hit_key <= 4'd8);
    assign wr_ok  = wr_en && (wr_cell <= 4'd8);

    // Hit first, then write, then clear_all: later steps override earlier ones.
    always_comb begin
        mask_next = mask;
        if (hit_ok)
            mask_next[hit_key] = 1'b0;
        if (wr_ok)
            mask_next[wr_cell] = wr_val;
        if (clear_all)
            mask_next = '0;
    end

`ifdef WAM_HIT_FLASH_EN
    logic [3:0] flash_cell;
    logic [3:0] flash_cnt;

    always_comb begin
        display = mask;
        if (flash_cnt != 4'd0)
            display[flash_cell] = ~flash_cnt[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flash_cell <= '0;
            flash_cnt  <= '0;
        end else if (clear_all) begin
            flash_cnt <= '0;
        end else if (hit_ok && mask[hit_key]) begin
            flash_cell <= hit_key;
            flash_cnt  <= FLASH_FRAMES;
        end else if (frame_tick && (flash_cnt != 4'd0)) begin
            flash_cnt <= flash_cnt - 4'd1;
        end
    end
`else
    assign display = mask;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            localparam logic [3:0] BASE = 4'(3 * gi);
            assign rows[gi] = display[BASE + {2'b00, col}];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre        <= '0;
            col        <= '0;
            mask       <= '0;
            col_n      <= 3'b111;
            row_out    <= 3'b000;
            frame_tick <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            pre        <= tick ? 16'd0 : pre + 16'd1;
            frame_tick <= tick && (col == 2'd2);
            wr_err     <= wr_en && (wr_cell > 4'd8);
            mask       <= mask_next;
            if (tick)
                col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
            // The cycle after a column tick is blanked so the old column never ghosts.
            if (tick) begin
                col_n   <= 3'b111;
                row_out <= 3'b000;
            end else begin
                col_n   <= ~(3'b001 << col);
                row_out <= rows;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Self-checking bench for led_matrix_driver: directed scenarios plus random traffic
// compared against a cycle-count based model of the scan and mask rules.
module tb_led_matrix_driver;

    localparam int SD = 3;
    localparam int PERIOD = SD + 1;
    localparam int FRAME = 3 * PERIOD;
    localparam int FF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_cell = '0;
    logic       wr_val = 1'b0;
    logic       clear_all = 1'b0;
    logic       hit_valid = 1'b0;
    logic [3:0] hit_key = '0;
    logic [2:0] col_n;
    logic [2:0] row_out;
    logic [8:0] mask;
    logic       frame_tick;
    logic       wr_err;

    int total = 0;
    int passes = 0;
    int fails = 0;

    // Model state: edges since reset release, mask, flash overlay, last frame_tick.
    int         t = 0;
    logic [8:0] mm = '0;
    int         fl_cell = 0;
    int         fl_left = 0;
    bit         prev_ft = 1'b0;

    always #5 clk = ~clk;

    led_matrix_driver #(
        .SCAN_DIV(16'(SD))
`ifdef WAM_HIT_FLASH_EN
        ,
        .FLASH_FRAMES(4'(FF))
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_cell(wr_cell),
        .wr_val(wr_val),
        .clear_all(clear_all),
        .hit_valid(hit_valid),
        .hit_key(hit_key),
        .col_n(col_n),
        .row_out(row_out),
        .mask(mask),
        .frame_tick(frame_tick),
        .wr_err(wr_err)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s t=%0d: got %h want %h", tag, t, obs, expv);
        end
    endtask

    task automatic step(input bit we, input int wc, input bit wv,
                        input bit clr, input bit hv, input int hk);
        logic [8:0] disp;
        logic [2:0] one;
        logic [2:0] ecn;
        logic [2:0] erow;
        int         tn, ph, c;
        bit         blank, eft, eerr, lit;
        wr_en = we; wr_cell = 4'(wc); wr_val = wv;
        clear_all = clr; hit_valid = hv; hit_key = 4'(hk);
        // Expected outputs after the coming edge, from the state before it.
        tn = t + 1;
        ph = tn % FRAME;
        c = ph / PERIOD;
        blank = (ph % PERIOD) == 0;
        disp = mm;
`ifdef WAM_HIT_FLASH_EN
        if (fl_left != 0) disp[fl_cell] = (fl_left % 2 == 0);
`endif
        one = 3'b001;
        ecn = blank ? 3'b111 : ~(one << c);
        erow = blank ? 3'b000 : {disp[6 + c], disp[3 + c], disp[c]};
        eft = (tn % FRAME) == 0;
        eerr = we && (wc > 8);
        @(posedge clk);
        #1;
        lit = hv && (hk <= 8) && mm[hk];
`ifdef WAM_HIT_FLASH_EN
        if (clr) fl_left = 0;
        else if (lit) begin fl_cell = hk; fl_left = FF; end
        else if (prev_ft && fl_left > 0) fl_left--;
`endif
        if (hv && hk <= 8) mm[hk] = 1'b0;
        if (we && wc <= 8) mm[wc] = wv;
        if (clr) mm = '0;
        prev_ft = eft;
        t = tn;
        chk("col_n", 9'(col_n), 9'(ecn));
        chk("row_out", 9'(row_out), 9'(erow));
        chk("mask", mask, mm);
        chk("frame_tick", 9'(frame_tick), 9'(eft));
        chk("wr_err", 9'(wr_err), 9'(eerr));
        if (we || clr || hv)
            $display("t=%0d we=%0d cell=%0d val=%0d clr=%0d hit=%0d key=%0d -> mask=%h lit=%0d",
                     t, we, wc, wv, clr, hv, hk, mask, lit);
        wr_en = 1'b0; clear_all = 1'b0; hit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_col_n"}, 9'(col_n), 9'h007);
        chk({tag, "_row_out"}, 9'(row_out), 9'h000);
        chk({tag, "_mask"}, mask, 9'h000);
        chk({tag, "_frame_tick"}, 9'(frame_tick), 9'h000);
        chk({tag, "_wr_err"}, 9'(wr_err), 9'h000);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        reset_check("async_rst");
        t = 0; mm = '0; fl_left = 0; prev_ft = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_check("held_rst");
        reset = 1'b1;
        $display("reset released");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_check("por");
        reset = 1'b1;

        // Idle scan, two full frames.
        idle(2 * FRAME);

        // Cell 4 and cell 8 lit.
        step(1, 4, 1, 0, 0, 0);
        step(1, 8, 1, 0, 0, 0);
        chk("mask_110", mask, 9'h110);
        idle(FRAME + 2);

        // Out-of-range write, then clear_all with a simultaneous write.
        step(1, 9, 1, 0, 0, 0);
        step(1, 15, 0, 0, 0, 0);
        step(1, 2, 1, 1, 0, 0);
        chk("clear_wins", mask, 9'h000);

        // Hit clears, write wins over same-cycle hit, out-of-range hit ignored.
        step(1, 4, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4);
        chk("hit_clear", mask, 9'h000);
        step(1, 4, 1, 0, 0, 0);
        step(1, 4, 1, 0, 1, 4);
        chk("write_over_hit", mask, 9'h010);
        step(0, 0, 0, 0, 1, 12);
        step(0, 0, 0, 0, 1, 5);
        idle(FRAME);

        // Hit on lit cell 0 (flash overlay when enabled), run past the flash.
        step(1, 0, 1, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0);
        idle((FF + 2) * FRAME);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, int'($urandom_range(0, 10)), 1'($urandom),
                 ($urandom % 24) == 0, ($urandom % 4) == 0, int'($urandom_range(0, 10)));
        end

        // Reset in the middle of column 2 with cells lit.
        step(1, 2, 1, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0);
        while ((t % FRAME) != 2 * PERIOD + 2) idle(1);
        do_reset();
        idle(FRAME + 2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/led_matrix_driver.md
# led_matrix_driver

Drives the 3x3 mole LED matrix by time-multiplexing its columns, mirroring how the keypad controller scans the 3x3 button matrix.
- Holds a 9-bit mole mask written by game logic.
- Clears a mole when the keypad reports a hit on its cell.
- Cell numbering matches the keypad: cell = 3*row + column, range 0-8.
- Sits between the game FSM and the board LED pins.

## Interface
Parameters:
- SCAN_DIV, 16'd8191: prescaler terminal count; one column is driven for SCAN_DIV+1 clocks.
- FLASH_FRAMES, 4'd8: number of scan frames a hit cell flashes (only with WAM_HIT_FLASH_EN).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  single-cycle write strobe.
- wr_cell  in  4  cell index for the write.
- wr_val  in  1  1 = light the cell, 0 = extinguish it.
- clear_all  in  1  extinguish all cells.
- hit_valid  in  1  keypad valid-key pulse.
- hit_key  in  4  keypad key index.
- col_n  out  3  active-low column drive, registered.
- row_out  out  3  active-high row drive, registered.
- mask  out  9  current mole mask, registered.
- frame_tick  out  1  one-clock pulse when column 2 wraps to column 0.
- wr_err  out  1  one-clock pulse on a write with wr_cell > 8.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV and wraps to 0. The cycle with pre == SCAN_DIV is a column tick.
- Column index `col` counts 0 -> 1 -> 2 -> 0, advancing on each tick. Value 3 is unreachable.
- A tick with col == 2 asserts frame_tick in the following cycle.
- Output drive:
  - On the clock after a tick, outputs blank for one cycle (col_n = 3'b111, row_out = 3'b000) for anti-ghosting.
  - Otherwise col_n = ~(1 << col) and row_out[r] = display[3r + col].
- display = mask, unless a flash overlay is active (see Configuration).
- Mask update order within one clock:
  1. A hit clears the mask bit (if hit_valid and hit_key <= 8).
  2. wr_en applies next, so a write wins over a hit on the same cell.
  3. clear_all overrides both.
- Write error handling: wr_cell > 8 with wr_en produces no mask change and wr_err = 1 for one clock. clear_all in the same cycle still clears.
- hit_key > 8 is ignored silently.
- A hit on an unlit cell leaves mask unchanged.

## Timing
- Reset values: pre = 0, col = 0, mask = 0, col_n = 3'b111, row_out = 3'b000, frame_tick = 0, wr_err = 0, flash inactive.
- A write or hit at clock edge N is visible on mask after edge N.
- row_out reflects the change after edge N+1 if its column is currently driven and no blank cycle intervenes. Otherwise it appears the next time that column is driven.
- Column period = SCAN_DIV+1 clocks, of which the first is blank. Frame = 3*(SCAN_DIV+1) clocks.
- frame_tick is asserted 1 clock out of every frame.
- wr_err is asserted on the clock after the offending write.
- Reset asserted mid-operation forces all reset values immediately (asynchronously). Scanning restarts at column 0 after deassertion.

## Configuration
- WAM_HIT_FLASH_EN defined:
  - A valid hit on a lit cell latches that cell and loads a frame counter with FLASH_FRAMES.
  - While the counter is nonzero, display forces that cell on during even frame counts and off during odd ones, overriding mask. The counter decrements on each frame_tick.
  - A new valid hit during a flash restarts the flash on the new cell.
  - clear_all cancels the flash.
  - A hit on an unlit cell does not start a flash.
- WAM_HIT_FLASH_EN undefined: display = mask always. Flash registers and the FLASH_FRAMES logic are absent. Hits only clear mask bits.

## Test plan
All scenarios use SCAN_DIV = 3.
- Reset release, no writes -> col_n sequence 111 (blank), 110 x3, 111, 101 x3, 111, 011 x3, repeating. row_out = 000 throughout. frame_tick pulses every 12 clocks.
- Write cell 4 = 1, then cell 8 = 1 -> mask = 9'h110. row_out = 3'b010 while col_n = 101, and 3'b100 while col_n = 011.
- wr_cell = 9 with wr_en -> mask unchanged, wr_err pulses for 1 clock. Then clear_all with wr_en (cell 2 = 1) in the same clock -> mask = 0.
- mask = 9'h010, hit_key = 4 with hit_valid -> mask = 0 next clock. Same-cycle hit on cell 4 plus write cell 4 = 1 -> mask = 9'h010.
- With WAM_HIT_FLASH_EN and FLASH_FRAMES = 4: hit on lit cell 0 -> row_out[0] high in column 0 during frames 4 and 2, low during frames 3 and 1, and dark once the counter reaches 0. Without the macro -> cell 0 goes dark immediately.
- Assert reset mid-column 2 -> outputs return to reset values in the same clock. The first driven column after release is 0.
